// File: rtl/regs_seq_if.sv
// regs_seq_if: instruction handshake plus register-file access bus of the
// picoMIPS register sequencer. The slave modport is the sequencer's side;
// the master modport is the fetch unit / register file side.
`timescale 1ns/1ps
interface regs_seq_if #(
  parameter int n = 8
);
  // Instruction handshake
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  // Register file access
  logic [1:0]    reg_raddr1;
  logic [1:0]    reg_raddr2;
  logic          reg_addr1;
  logic          reg_addr2;
  logic          reg_fetch;
  logic          reg_w;
  logic [n-1:0]  reg_wdata;
  logic [n-1:0]  reg_rdata1;
  logic [n-1:0]  reg_rdata2;

  modport slave (
    input  instr_valid, instr, reg_rdata1, reg_rdata2,
    output instr_ready, reg_raddr1, reg_raddr2, reg_addr1, reg_addr2,
           reg_fetch, reg_w, reg_wdata
  );

  modport master (
    output instr_valid, instr, reg_rdata1, reg_rdata2,
    input  instr_ready, reg_raddr1, reg_raddr2, reg_addr1, reg_addr2,
           reg_fetch, reg_w, reg_wdata
  );
endinterface

// File: rtl/regs_seq.sv
// regs_seq: register-access sequencer for the picoMIPS 4 x n register file.
// Accepts one instruction word at a time, reads the operands through the
// register file's read ports, computes the result and issues a single
// write-back. Instruction flow per word: IDLE -> READ -> EXEC -> WB.
// Optional feature: define REGS_SEQ_FLAGS_EN to get live zero/carry flags;
// without it both flags are tied low.
`timescale 1ns/1ps
module regs_seq #(
  parameter int n = 8
) (
  input  logic      clk,
  input  logic      nReset,
  regs_seq_if.slave bus,
  output logic      done,
  output logic      illegal,
  output logic      zero,
  output logic      carry
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_LDI  = 4'd4;
  localparam logic [3:0] OP_MOV  = 4'd5;

  state_t         state_reg, state_next;
  logic [15:0]    instr_reg;
  logic [n-1:0]   op1_reg, op2_reg, result_reg;
  logic           illegal_reg;

  logic [3:0]     op;
  logic [1:0]     rd, rs;
  logic [n-1:0]   imm;
  logic           op_legal, op_nop;
  logic [n:0]     sum;

  assign op       = instr_reg[15:12];
  assign rd       = instr_reg[11:10];
  assign rs       = instr_reg[9:8];
  assign op_legal = (op <= OP_MOV);
  assign op_nop   = (op == OP_NOP);

  // The immediate field is 8 bits; use its low n bits, zero-extended if n is wider.
  generate
    if (n > 8) begin : g_imm_wide
      assign imm = {{(n-8){1'b0}}, instr_reg[7:0]};
    end else if (n == 8) begin : g_imm_exact
      assign imm = instr_reg[7:0];
    end else begin : g_imm_narrow
      assign imm = instr_reg[n-1:0];
    end
  endgenerate

  // State register; reset drops any in-flight instruction.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state and register-file control outputs, decoded from the state.
  always_comb begin
    state_next      = state_reg;
    bus.instr_ready = 1'b0;
    bus.reg_raddr1  = 2'd0;
    bus.reg_raddr2  = 2'd0;
    bus.reg_addr1   = 1'b0;
    bus.reg_addr2   = 1'b0;
    bus.reg_fetch   = 1'b0;
    bus.reg_w       = 1'b0;
    bus.reg_wdata   = '0;
    done            = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_next = READ;
      end
      READ: begin
        bus.reg_raddr1 = rd;
        bus.reg_raddr2 = rs;
        // MOV ignores rd's contents, so Rdata1 is forced to zero (0 + rs).
        bus.reg_addr1  = (rd == 2'd0) || (op == OP_MOV);
        bus.reg_addr2  = (rs == 2'd0);
        bus.reg_fetch  = (op == OP_LDI);
        state_next     = (op_nop || !op_legal) ? WB : EXEC;
      end
      EXEC: begin
        state_next = WB;
      end
      WB: begin
        bus.reg_raddr1 = rd;
        bus.reg_wdata  = result_reg;
        // %0 is read-as-zero; writes to it are dropped.
        bus.reg_w      = op_legal && !op_nop && (rd != 2'd0);
        done           = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU: (n+1)-bit sum so bit n is the carry, or the borrow for SUB.
  always_comb begin
    sum = '0;
    case (op)
      OP_ADD:  sum = {1'b0, op1_reg} + {1'b0, op2_reg};
      OP_SUB:  sum = {1'b0, op1_reg} - {1'b0, op2_reg};
      OP_ADDI: sum = {1'b0, op1_reg} + {1'b0, imm};
      OP_LDI:  sum = {1'b0, imm};
      OP_MOV:  sum = {1'b0, op2_reg};
      default: sum = '0;
    endcase
  end

  // Datapath: latch the instruction, capture operands, register the result.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      instr_reg   <= 16'd0;
      op1_reg     <= '0;
      op2_reg     <= '0;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (bus.instr_valid) instr_reg <= bus.instr;
        READ: begin
          op1_reg <= bus.reg_rdata1;
          op2_reg <= bus.reg_rdata2;
          if (!op_legal) illegal_reg <= 1'b1;
        end
        EXEC: result_reg <= sum[n-1:0];
        default: ;
      endcase
    end
  end

  assign illegal = illegal_reg;

`ifdef REGS_SEQ_FLAGS_EN
  logic zero_reg, carry_reg;

  // Flags follow each arithmetic/load result and hold otherwise.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
    end else if (state_reg == EXEC) begin
      zero_reg  <= (sum[n-1:0] == '0);
      carry_reg <= sum[n];
    end
  end

  assign zero  = zero_reg;
  assign carry = carry_reg;
`else
  logic carry_bit_unused;
  assign carry_bit_unused = sum[n];
  assign zero  = 1'b0;
  assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_regs_seq.sv
// tb_regs_seq: scoreboard bench for regs_seq. A driver issues directed then
// random instruction words, predicts each outcome from a plain register
// array and pushes it; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_regs_seq;
  localparam int N = 8;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic done, illegal, zero, carry;

  regs_seq_if #(.n(N)) bus ();

  regs_seq #(.n(N)) dut (
    .clk(clk), .nReset(nReset), .bus(bus),
    .done(done), .illegal(illegal), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file seen by the DUT; r0 holds junk so zero-forcing matters.
  logic [N-1:0] rf [4] = '{8'hA5, 8'h11, 8'h22, 8'h33};
  always_comb begin
    bus.reg_rdata1 = (bus.reg_addr1 || bus.reg_fetch) ? '0 : rf[bus.reg_raddr1];
    bus.reg_rdata2 = bus.reg_addr2 ? '0 : rf[bus.reg_raddr2];
  end
  always @(posedge clk) if (bus.reg_w) rf[bus.reg_raddr1] <= bus.reg_wdata;

  // Reference state: architectural registers (r0 reads as 0) and flags.
  int ref_r [4] = '{0, 'h11, 'h22, 'h33};
  bit ref_z = 0, ref_c = 0, ref_ill = 0;

  typedef struct {
    bit          we;
    bit          chk;
    logic [1:0]  waddr;
    logic [7:0]  wdata;
    bit          z, c, ill;
    int          done_cyc;
  } exp_t;
  exp_t sbq[$];

  int tests = 0, fails = 0;
  int last_accept = -1, last_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Predict the outcome of one instruction from the architectural rules.
  task automatic predict(input logic [15:0] ins, input int acc, output exp_t e);
    int op, rd, rs, imm, a, b, full, res;
    bit c;
    op = int'(ins[15:12]); rd = int'(ins[11:10]); rs = int'(ins[9:8]); imm = int'(ins[7:0]);
    a = (rd == 0) ? 0 : ref_r[rd];
    b = (rs == 0) ? 0 : ref_r[rs];
    res = 0; c = 0;
    case (op)
      1: begin full = a + b;   res = full % 256; c = (full > 255); end
      2: begin res = (a - b + 256) % 256; c = (b > a); end
      3: begin full = a + imm; res = full % 256; c = (full > 255); end
      4: res = imm;
      5: res = b;
      default: ;
    endcase
    e.chk = (op >= 1 && op <= 5);
    e.we = e.chk && (rd != 0);
    e.waddr = ins[11:10];
    e.wdata = res[7:0];
    if (e.we) ref_r[rd] = res;
    if (e.chk) begin ref_z = (res == 0); ref_c = c; end
    if (op > 5) ref_ill = 1;
`ifdef REGS_SEQ_FLAGS_EN
    e.z = ref_z; e.c = ref_c;
`else
    e.z = 0; e.c = 0;
`endif
    e.ill = ref_ill;
    e.done_cyc = acc + ((op == 0 || op > 5) ? 2 : 3);
  endtask

  // Issue one word (called at a negedge); returns at the READ-cycle negedge
  // with instr_valid still high so a following call is back-to-back.
  task automatic send(input logic [15:0] ins);
    exp_t e;
    int w = 0;
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    while (!bus.instr_ready) begin
      @(negedge clk);
      w++;
      if (w > 20) begin
        check("accept_timeout", 0, 1);
        bus.instr_valid = 1'b0;
        return;
      end
    end
    if (last_accept >= 0) check("b2b_spacing", cyc - last_accept, last_gap);
    last_accept = cyc;
    last_gap = (ins[15:12] == 0 || ins[15:12] > 5) ? 3 : 4;
    predict(ins, cyc, e);
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check("read_ctrl",
          {bus.reg_raddr1, bus.reg_raddr2, bus.reg_addr1, bus.reg_addr2, bus.reg_fetch, bus.reg_w},
          {ins[11:10], ins[9:8], (ins[11:10] == 0) || (ins[15:12] == 5),
           ins[9:8] == 0, ins[15:12] == 4, 1'b0});
    check("ready_busy", bus.instr_ready, 0);
  endtask

  task automatic idle(input int k);
    bus.instr_valid = 1'b0;
    repeat (k) @(negedge clk);
    last_accept = -1;
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 20) begin @(negedge clk); k++; end
    check("drain", sbq.size(), 0);
  endtask

  // Monitor: compares every retirement against the scoreboard head.
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("wb_reg_w", bus.reg_w, e.we);
        if (e.chk) begin
          check("wb_waddr", bus.reg_raddr1, e.waddr);
          check("wb_wdata", bus.reg_wdata, e.wdata);
        end
        check("flags", {zero, carry}, {e.z, e.c});
        check("illegal", illegal, e.ill);
        $display("[TB] retire cyc=%0d we=%0d addr=%0d data=%02h z=%0d c=%0d ill=%0d",
                 cyc, bus.reg_w, bus.reg_raddr1, bus.reg_wdata, zero, carry, illegal);
      end
    end else begin
      check("reg_w_outside_wb", bus.reg_w, 0);
    end
  end

  initial begin
    logic [15:0] directed [12];
    directed = '{16'h447F, 16'h44F0, 16'h4820, 16'h1600, 16'h4405, 16'h4805,
                 16'h2600, 16'h4403, 16'h2600, 16'h3012, 16'h9000, 16'h5D00};
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    #12;
    check("reset_state",
          {bus.instr_ready, bus.reg_w, done, illegal, zero, carry, bus.reg_raddr1,
           bus.reg_raddr2, bus.reg_addr1, bus.reg_addr2, bus.reg_fetch},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0});
    check("reset_wdata", bus.reg_wdata, 0);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    // Directed sequence, issued back-to-back with instr_valid held high.
    foreach (directed[i]) send(directed[i]);
    idle(1);
    drain();

    // Reset pulse during EXEC of an ADD: no write, no retirement.
    bus.instr = 16'h1600;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    nReset = 1'b0;
    #2;
    check("rst_mid_ready", bus.instr_ready, 1);
    check("rst_mid_outs", {bus.reg_w, done, zero, carry, illegal}, 0);
    ref_z = 0; ref_c = 0; ref_ill = 0;
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    check("rst_release_ready", bus.instr_ready, 1);
    repeat (4) @(negedge clk);
    last_accept = -1;

    // Randomized traffic with occasional gaps.
    for (int i = 0; i < 150; i++) begin
      logic [15:0] ins;
      int op;
      op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : int'($urandom_range(6, 15));
      ins = {op[3:0], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
      send(ins);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
